// File: rtl/wishbone_mem_master.sv
// Wishbone classic master moving cmd_count words between a stream port and the bus.
// Each word is one registered strobe, with a GAP cycle between words and a per-strobe ack timeout.
module wishbone_mem_master #(
  parameter int          TIMEOUT = 255,
  parameter logic [3:0]  SEL     = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_count,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic        cmd_error,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_int_i,
  output logic        irq_pulse
);

  typedef enum logic [2:0] {IDLE, WDATA, STROBE, GAP, FINISH} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, next_state;
  logic        write_q;
  logic [15:0] cnt_q, wait_q;
  logic        int_s, int_p;

  logic        start, ack_take, accept, timeout, eff_write;
  logic        busy_d, done_d, cyc_d, stb_d, we_d, rdy_d, rdv_d, err_d, write_d;
  logic [3:0]  sel_d;
  logic [31:0] adr_d, dat_d, rdd_d;
  logic [15:0] cnt_d, wait_d;

  assign start     = (state == IDLE) && cmd_start;
  assign ack_take  = (state == STROBE) && wbm_ack_i;
  assign accept    = (state == WDATA) && wr_valid && wr_ready;
  assign timeout   = (state == STROBE) && !wbm_ack_i && (wait_q == WAIT_LAST);
  // The latched direction is not valid yet in the cycle the command is taken.
  assign eff_write = (state == IDLE) ? cmd_write : write_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_start) begin
                 if (cmd_count == 16'd0) next_state = FINISH;
                 else if (cmd_write)     next_state = WDATA;
                 else                    next_state = STROBE;
               end
      WDATA:   if (accept) next_state = STROBE;
      STROBE:  if (wbm_ack_i)   next_state = (cnt_q == 16'd1) ? FINISH : GAP;
               else if (timeout) next_state = FINISH;
      GAP:     next_state = write_q ? WDATA : STROBE;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == FINISH);
    cyc_d   = (next_state == WDATA) || (next_state == STROBE) || (next_state == GAP);
    stb_d   = (next_state == STROBE);
    we_d    = stb_d && eff_write;
    sel_d   = stb_d ? SEL : 4'h0;
    rdy_d   = (next_state == WDATA);
    write_d = start ? cmd_write : write_q;
    adr_d   = start ? cmd_addr : (ack_take ? wbm_adr_o + 32'd1 : wbm_adr_o);
    cnt_d   = start ? cmd_count : (ack_take ? cnt_q - 16'd1 : cnt_q);
    dat_d   = accept ? wr_data : wbm_dat_o;
    rdv_d   = ack_take && !write_q;
    rdd_d   = rdv_d ? wbm_dat_i : rd_data;
    err_d   = start ? 1'b0 : (timeout ? 1'b1 : cmd_error);
    if ((next_state == STROBE) && (state != STROBE)) wait_d = 16'd0;
    else if ((state == STROBE) && !wbm_ack_i)        wait_d = wait_q + 16'd1;
    else                                             wait_d = wait_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_busy  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_error <= 1'b0;
      wr_ready  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      wait_q    <= '0;
    end else begin
      cmd_busy  <= busy_d;
      cmd_done  <= done_d;
      cmd_error <= err_d;
      wr_ready  <= rdy_d;
      rd_data   <= rdd_d;
      rd_valid  <= rdv_d;
      wbm_we_o  <= we_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
    end
  end

  // Interrupt edge is taken on the sampled copy, so the pulse trails the input by a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_s     <= 1'b0;
      int_p     <= 1'b0;
      irq_pulse <= 1'b0;
    end else begin
      int_s     <= wbm_int_i;
      int_p     <= int_s;
      irq_pulse <= int_s && !int_p;
    end
  end

endmodule

// File: tb/tb_wishbone_mem_master.sv
// Directed bench for wishbone_mem_master: a Wishbone slave model acking one cycle after stb,
// with address/data scoreboards filled when commands are issued and drained by a bus monitor.
module tb_wishbone_mem_master;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_start = 0, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [15:0] cmd_count = 0;
  logic        cmd_busy, cmd_done, cmd_error;
  logic [31:0] wr_data = 0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 0;
  logic        wbm_ack_i = 0, wbm_int_i = 0, irq_pulse;

  int checks = 0, errors = 0;
  int stb_cyc = 0, gap_cyc = 0, fin_cyc = 0, done_cnt = 0, irq_cnt = 0;
  bit ack_en = 1;
  logic [31:0] exp_adr[$], exp_wdat[$], exp_rd[$];
  bit          exp_we[$];

  wishbone_mem_master #(.TIMEOUT(4), .SEL(4'hF)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_int_i(wbm_int_i), .irq_pulse(irq_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor and slave share the falling edge; the stimulus runs 1 time unit later.
  always @(negedge clk) begin
    if (!rst) begin
      if (wbm_stb_o) stb_cyc++;
      if (wbm_cyc_o && !wbm_stb_o && !wr_ready) gap_cyc++;
      if (cmd_busy && !wbm_cyc_o) fin_cyc++;
      if (cmd_done) done_cnt++;
      if (irq_pulse) irq_cnt++;
      if (rd_valid) begin
        check("rd_sb_avail", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (wbm_stb_o && wbm_cyc_o && ack_en && !wbm_ack_i) begin
        check("adr_sb_avail", 32'(exp_adr.size() > 0), 1);
        if (exp_adr.size() > 0) begin
          check("adr", wbm_adr_o, exp_adr.pop_front());
          check("we", 32'(wbm_we_o), 32'(exp_we.pop_front()));
        end
        check("sel_on_stb", 32'(wbm_sel_o), 32'hF);
        check("rdy_low_on_stb", 32'(wr_ready), 0);
        if (wbm_we_o) begin
          check("wdat_sb_avail", 32'(exp_wdat.size() > 0), 1);
          if (exp_wdat.size() > 0) check("dat_o", wbm_dat_o, exp_wdat.pop_front());
        end
      end
    end
    wbm_ack_i = wbm_stb_o && wbm_cyc_o && ack_en && !wbm_ack_i;
    wbm_dat_i = slave_word(wbm_adr_o);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_cmd(input bit w, input logic [31:0] a, input logic [15:0] n);
    cmd_write = w; cmd_addr = a; cmd_count = n; cmd_start = 1;
    tick();
    cmd_start = 0;
  endtask

  task automatic push_read(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(a + 32'(i)); exp_we.push_back(0); exp_rd.push_back(slave_word(a + 32'(i)));
    end
  endtask

  task automatic wait_done(input int d0, input int bound);
    int k = 0;
    while (done_cnt == d0 && k < bound) begin tick(); k++; end
    check("done_within_bound", 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_ready(input int bound);
    int k = 0;
    while (!wr_ready && k < bound) begin tick(); k++; end
    check("wr_ready_within_bound", 32'(wr_ready), 1);
  endtask

  initial begin
    int d0, s0, g0, f0, i0;
    #3;
    check("rst_busy", 32'(cmd_busy), 0);
    check("rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 0);
    check("rst_sel", 32'(wbm_sel_o), 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat_o", wbm_dat_o, 0);
    check("rst_rd", {rd_data[30:0], rd_valid}, 0);
    check("rst_flags", {27'd0, cmd_error, cmd_done, irq_pulse, wr_ready, wbm_we_o}, 0);
    tick(); tick();
    rst = 0;
    tick();

    // Three-word read
    d0 = done_cnt; g0 = gap_cyc; s0 = stb_cyc;
    push_read(32'h100, 3);
    start_cmd(0, 32'h100, 3);
    wait_done(d0, 40);
    tick(); tick();
    check("rd3_done_once", 32'(done_cnt - d0), 1);
    check("rd3_gaps", 32'(gap_cyc - g0), 2);
    check("rd3_stb_cycles", 32'(stb_cyc - s0), 3);
    check("rd3_error", 32'(cmd_error), 0);
    check("rd3_idle", 32'(cmd_busy), 0);

    // Two-word write with wr_valid held back 3 cycles per word
    d0 = done_cnt; f0 = fin_cyc; g0 = gap_cyc;
    exp_adr.push_back(32'h20); exp_we.push_back(1); exp_wdat.push_back(32'hDEADBEEF);
    exp_adr.push_back(32'h21); exp_we.push_back(1); exp_wdat.push_back(32'h12345678);
    start_cmd(1, 32'h20, 2);
    for (int w = 0; w < 2; w++) begin
      wait_ready(20);
      repeat (3) tick();
      wr_data = (w == 0) ? 32'hDEADBEEF : 32'h12345678;
      wr_valid = 1;
      tick();
      wr_valid = 0;
    end
    wait_done(d0, 40);
    tick(); tick();
    check("wr2_done_once", 32'(done_cnt - d0), 1);
    check("wr2_cyc_drop_only_in_finish", 32'(fin_cyc - f0), 1);
    check("wr2_gap", 32'(gap_cyc - g0), 1);
    check("wr2_sb_empty", 32'(exp_wdat.size() + exp_adr.size()), 0);

    // Timeout: no ack, TIMEOUT=4
    ack_en = 0; d0 = done_cnt; s0 = stb_cyc;
    start_cmd(0, 32'h300, 1);
    wait_done(d0, 40);
    check("to_cyc_stb_low", {30'd0, wbm_cyc_o, wbm_stb_o}, 0);
    tick(); tick();
    check("to_stb_cycles", 32'(stb_cyc - s0), 4);
    check("to_error", 32'(cmd_error), 1);
    check("to_idle", 32'(cmd_busy), 0);
    ack_en = 1;

    // Zero count: done with no strobe, clears the held error
    d0 = done_cnt; s0 = stb_cyc;
    start_cmd(0, 32'h700, 0);
    wait_done(d0, 10);
    tick();
    check("zero_no_stb", 32'(stb_cyc - s0), 0);
    check("zero_done", 32'(done_cnt - d0), 1);
    check("zero_error_cleared", 32'(cmd_error), 0);

    // Start while busy is ignored
    d0 = done_cnt; s0 = stb_cyc;
    push_read(32'h400, 2);
    start_cmd(0, 32'h400, 2);
    check("busy_after_start", 32'(cmd_busy), 1);
    start_cmd(1, 32'h999, 5);
    wait_done(d0, 40);
    repeat (8) tick();
    check("busy_start_ignored_done", 32'(done_cnt - d0), 1);
    check("busy_start_ignored_stb", 32'(stb_cyc - s0), 2);
    check("busy_start_idle", 32'(cmd_busy), 0);

    // Reset in the middle of a write strobe
    ack_en = 0;
    start_cmd(1, 32'h500, 2);
    wait_ready(20);
    wr_data = 32'hA5A5A5A5; wr_valid = 1;
    tick();
    wr_valid = 0;
    check("mid_wr_stb", 32'(wbm_stb_o), 1);
    rst = 1;
    #1;
    check("async_rst_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 0);
    check("async_rst_busy", 32'(cmd_busy), 0);
    tick();
    rst = 0; ack_en = 1;
    tick();
    d0 = done_cnt;
    push_read(32'h600, 1);
    start_cmd(0, 32'h600, 1);
    wait_done(d0, 20);
    tick();
    check("post_rst_error", 32'(cmd_error), 0);

    // Address wrap and interrupt edge
    d0 = done_cnt;
    exp_adr.push_back(32'hFFFFFFFF); exp_we.push_back(0); exp_rd.push_back(slave_word(32'hFFFFFFFF));
    exp_adr.push_back(32'h0);        exp_we.push_back(0); exp_rd.push_back(slave_word(32'h0));
    start_cmd(0, 32'hFFFFFFFF, 2);
    wait_done(d0, 20);
    tick(); tick();
    i0 = irq_cnt;
    wbm_int_i = 1;
    repeat (10) tick();
    check("irq_one_pulse", 32'(irq_cnt - i0), 1);
    wbm_int_i = 0;
    tick();
    check("sb_drained", 32'(exp_adr.size() + exp_rd.size() + exp_wdat.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
